// File: rtl/regfile_sb.sv
// Byte-strobed register file with a per-register busy scoreboard and a population-count output.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle write data and clear busy on the read ports.
module regfile_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                wen,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic [ADDR_W-1:0]   raddr1,
    input  logic [ADDR_W-1:0]   raddr2,
    output logic [DATA_W-1:0]   rdata1,
    output logic [DATA_W-1:0]   rdata2,
    output logic                rbusy1,
    output logic                rbusy2,
    input  logic                iss_valid,
    input  logic [ADDR_W-1:0]   iss_addr,
    input  logic [ADDR_W-1:0]   test_addr,
    output logic [DATA_W-1:0]   test_data,
    output logic [ADDR_W:0]     busy_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned NB    = DATA_W / 8;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [ADDR_W:0]   cnt_nxt;
    logic [DATA_W-1:0] merged;
    logic              write_ok;

    always_comb begin
        write_ok = wen && !((ZERO_REG != 0) && (waddr == '0));
        merged   = regs[waddr];
        for (int unsigned i = 0; i < NB; i++) begin
            if (wstrb[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    // Clear first, then set, so a same-edge issue to the written register keeps it busy.
    always_comb begin
        busy_nxt = busy;
        if (wen && (wstrb != '0)) begin
            busy_nxt[waddr] = 1'b0;
        end
        if (iss_valid) begin
            busy_nxt[iss_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_nxt[0] = 1'b0;
        end
        cnt_nxt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (write_ok) begin
                regs[waddr] <= merged;
            end
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    assign test_data = regs[test_addr];

`ifdef REGFILE_SB_BYPASS_EN
    logic byp1;
    logic byp2;

    // Gated by resetn so an in-flight write cannot leak onto the read ports during reset.
    always_comb begin
        byp1   = resetn && write_ok && (raddr1 == waddr);
        byp2   = resetn && write_ok && (raddr2 == waddr);
        rdata1 = byp1 ? merged : regs[raddr1];
        rdata2 = byp2 ? merged : regs[raddr2];
        rbusy1 = byp1 ? 1'b0 : busy[raddr1];
        rbusy2 = byp2 ? 1'b0 : busy[raddr2];
    end
`else
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        rbusy1 = busy[raddr1];
        rbusy2 = busy[raddr2];
    end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed literal checks plus randomized traffic against an array model.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        rbusy1, rbusy2;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic [4:0]  test_addr;
    logic [31:0] test_data;
    logic [5:0]  busy_cnt;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk(clk), .resetn(resetn), .wen(wen), .waddr(waddr), .wdata(wdata),
        .wstrb(wstrb), .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1),
        .rdata2(rdata2), .rbusy1(rbusy1), .rbusy2(rbusy2), .iss_valid(iss_valid),
        .iss_addr(iss_addr), .test_addr(test_addr), .test_data(test_data),
        .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old);
        logic [31:0] v = old;
        for (int b = 0; b < 4; b++)
            if (wstrb[b]) v[8*b +: 8] = wdata[8*b +: 8];
        return v;
    endfunction

    function automatic bit model_bypass(input logic [4:0] ra);
`ifdef REGFILE_SB_BYPASS_EN
        return resetn && wen && (ra == waddr) && (waddr != 0);
`else
        return (ra == 5'd31) && 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [4:0] ra);
        return model_bypass(ra) ? model_merge(m_regs[ra]) : m_regs[ra];
    endfunction

    function automatic logic exp_rbusy(input logic [4:0] ra);
        return model_bypass(ra) ? 1'b0 : m_busy[ra];
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += m_busy[i];
        return n;
    endfunction

    always @(negedge resetn) model_clear();

    always @(posedge clk) begin
        if (resetn === 1'b1) begin
            if (wen && waddr != 0) m_regs[waddr] = model_merge(m_regs[waddr]);
            if (wen && wstrb != 0) m_busy[waddr] = 1'b0;
            if (iss_valid && iss_addr != 0) m_busy[iss_addr] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("rdata1", rdata1, exp_rdata(raddr1));
            check("rdata2", rdata2, exp_rdata(raddr2));
            check("rbusy1", rbusy1, exp_rbusy(raddr1));
            check("rbusy2", rbusy2, exp_rbusy(raddr2));
            check("test_data", test_data, m_regs[test_addr]);
            check("busy_cnt", busy_cnt, model_count());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen = 1'b0; wstrb = '0; iss_valid = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        wen = 1'b1; waddr = a; wdata = d; wstrb = s;
    endtask

    initial begin
        model_clear();
        resetn = 1'b0;
        idle();
        waddr = '0; wdata = '0; raddr1 = 5'd5; raddr2 = '0; iss_addr = '0; test_addr = 5'd5;
        #12;
        check("reset_rdata1", rdata1, 32'h0);
        check("reset_busy_cnt", busy_cnt, 6'd0);
        check("reset_test_data", test_data, 32'h0);
        resetn = 1'b1;
        step();
        chk_en = 1'b1;

        do_write(5'd5, 32'h12345678, 4'hF);
        step();
        idle();
        #1;
        check("wr_full_rdata1", rdata1, 32'h12345678);
        check("wr_full_test_data", test_data, 32'h12345678);

        do_write(5'd5, 32'hAABBCCDD, 4'h5);
        step();
        idle();
        #1;
        check("wr_strb_rdata1", rdata1, 32'h12BB56DD);

        do_write(5'd0, 32'hFFFFFFFF, 4'hF);
        iss_valid = 1'b1; iss_addr = 5'd0;
        step();
        idle(); raddr1 = 5'd0; test_addr = 5'd0;
        #1;
        check("zero_rdata1", rdata1, 32'h0);
        check("zero_busy_cnt", busy_cnt, 6'd0);
        check("zero_test_data", test_data, 32'h0);

        raddr1 = 5'd7;
        iss_valid = 1'b1; iss_addr = 5'd7;
        step();
        do_write(5'd7, 32'h77777777, 4'hF);
        step();
        idle();
        #1;
        check("setwins_rbusy1", rbusy1, 1'b1);
        check("setwins_busy_cnt", busy_cnt, 6'd1);
        do_write(5'd7, 32'h77770000, 4'hF);
        step();
        idle();
        #1;
        check("clear_rbusy1", rbusy1, 1'b0);
        check("clear_busy_cnt", busy_cnt, 6'd0);

        do_write(5'd3, 32'h11111111, 4'hF);
        iss_valid = 1'b1; iss_addr = 5'd3;
        step();
        iss_valid = 1'b0;
        do_write(5'd3, 32'hCAFEF00D, 4'hF);
        raddr2 = 5'd3;
        #1;
`ifdef REGFILE_SB_BYPASS_EN
        check("byp_rdata2", rdata2, 32'hCAFEF00D);
        check("byp_rbusy2", rbusy2, 1'b0);
`else
        check("nobyp_rdata2", rdata2, 32'h11111111);
        check("nobyp_rbusy2", rbusy2, 1'b1);
`endif
        step();
        idle();
        #1;
        check("after_wr_rdata2", rdata2, 32'hCAFEF00D);
        check("after_wr_rbusy2", rbusy2, 1'b0);

        do_write(5'd9, 32'hDEADBEEF, 4'hF);
        raddr1 = 5'd9;
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle();
        #1;
        check("midwrite_lost", rdata1, 32'h0);
        do_write(5'd9, 32'h0BADF00D, 4'hF);
        step();
        idle();
        #1;
        check("post_reset_write", rdata1, 32'h0BADF00D);

        raddr1 = 5'd5;
        do_write(5'd5, 32'h55AA55AA, 4'hF);
        step();
        idle();
        for (int a = 1; a < 32; a++) begin
            iss_valid = 1'b1; iss_addr = 5'(a);
            step();
        end
        idle();
        step();
        check("all_busy_cnt", busy_cnt, 6'd31);
        resetn = 1'b0;
        #1;
        check("async_busy_cnt", busy_cnt, 6'd0);
        check("async_rbusy1", rbusy1, 1'b0);
        check("async_rdata1", rdata1, 32'h0);
        check("async_test_data", test_data, 32'h0);
        #1;
        resetn = 1'b1;
        step();

        for (int n = 0; n < 3000; n++) begin
            bit narrow = ($urandom_range(0, 1) == 1);
            wen       = ($urandom_range(0, 2) != 0);
            waddr     = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wdata     = $urandom;
            wstrb     = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            iss_valid = ($urandom_range(0, 1) == 1);
            iss_addr  = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            raddr1    = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            raddr2    = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            test_addr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            step();
        end
        idle();
        step();
        step();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
